// File: rtl/ysyx_23060096_rf_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_rf_pkg
// Shared defaults for the multi-port register file and its scoreboard.
// No ports; imported by ysyx_23060096_regfile_mp and ysyx_23060096_rf_scoreboard.
// Optional feature macro used by the register file: YSYX_RF_BYPASS_EN.
// ---------------------------------------------------------------------------
package ysyx_23060096_rf_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_NR_RD      = 4;
    localparam int RF_NR_WR      = 2;
    localparam int RF_ZERO_REG   = 1;
    localparam int RF_DEPTH      = 1 << RF_ADDR_WIDTH;

endpackage

// File: rtl/ysyx_23060096_rf_scoreboard.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_rf_scoreboard
// Per-register busy bits plus a registered population count.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   wen, waddr     : writeback ports (clear busy)
//   rsv_en,rsv_addr: issue-slot reservations (set busy)
//   flush          : clear every busy bit
//   busy           : current busy vector, one bit per register
//   busy_cnt       : number of busy registers
// ---------------------------------------------------------------------------
module ysyx_23060096_rf_scoreboard
    import ysyx_23060096_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NR_WR      = RF_NR_WR,
    parameter int ZERO_REG   = RF_ZERO_REG,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NR_WR-1:0]            wen,
    input  logic [NR_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NR_WR-1:0]            rsv_en,
    input  logic [NR_WR*ADDR_WIDTH-1:0] rsv_addr,
    input  logic                        flush,
    output logic [DEPTH-1:0]            busy,
    output logic [ADDR_WIDTH:0]         busy_cnt
);

    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [ADDR_WIDTH:0] busy_cnt_q, busy_cnt_d;
    logic [DEPTH-1:0]    set_vec, clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int j = 0; j < NR_WR; j++) begin
            if (wen[j])    clr_vec[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]]    = 1'b1;
            if (rsv_en[j]) set_vec[rsv_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
        end

        // Set is applied after clear: a new producer supersedes a same-cycle
        // writeback of the old one. Flush drops everything, reservations included.
        busy_d = flush ? '0 : ((busy_q & ~clr_vec) | set_vec);
        if (ZERO_REG != 0) busy_d[0] = 1'b0;

        busy_cnt_d = '0;
        for (int r = 0; r < DEPTH; r++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_WIDTH+1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/ysyx_23060096_regfile_mp.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_regfile_mp
// Multi-port architectural register file with integrated busy scoreboard.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   raddr/rdata/rready : NR_RD combinational read ports, packed port i at
//                        [i*W +: W]; rready=1 when the register is not busy
//   wen/waddr/wdata    : NR_WR synchronous write ports, higher port wins
//   rsv_en/rsv_addr    : per issue slot destination reservation
//   flush              : clear all busy bits, data kept
//   busy_cnt           : registered count of busy registers
// Macro YSYX_RF_BYPASS_EN: when defined, reads forward same-cycle write data
// and report ready; otherwise reads see the registered contents only.
// ---------------------------------------------------------------------------
module ysyx_23060096_regfile_mp
    import ysyx_23060096_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int NR_RD      = RF_NR_RD,
    parameter int NR_WR      = RF_NR_WR,
    parameter int ZERO_REG   = RF_ZERO_REG
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NR_RD*DATA_WIDTH-1:0] rdata,
    output logic [NR_RD-1:0]            rready,
    input  logic [NR_WR-1:0]            wen,
    input  logic [NR_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NR_WR*DATA_WIDTH-1:0] wdata,
    input  logic [NR_WR-1:0]            rsv_en,
    input  logic [NR_WR*ADDR_WIDTH-1:0] rsv_addr,
    input  logic                        flush,
    output logic [ADDR_WIDTH:0]         busy_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf_q [DEPTH];
    logic [DATA_WIDTH-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0]      busy;

    ysyx_23060096_rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NR_WR      (NR_WR),
        .ZERO_REG   (ZERO_REG),
        .DEPTH      (DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .waddr    (waddr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // Ports are applied in ascending order so the highest-index port wins.
    always_comb begin
        rf_d = rf_q;
        for (int j = 0; j < NR_WR; j++) begin
            if (wen[j] && !(ZERO_REG != 0 && waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                rf_d[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            rf_q[k] <= rst ? '0 : rf_d[k];
        end
    end

    always_comb begin
        rdata  = '0;
        rready = '0;
        for (int i = 0; i < NR_RD; i++) begin
            rdata[i*DATA_WIDTH +: DATA_WIDTH] = rf_q[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
            rready[i] = ~busy[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef YSYX_RF_BYPASS_EN
            // Ascending scan leaves the highest-index matching port in place.
            for (int j = 0; j < NR_WR; j++) begin
                if (wen[j] && waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == raddr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
                    rready[i] = 1'b1;
                end
            end
`endif
            // Register 0 is never bypassed and always ready.
            if (ZERO_REG != 0 && raddr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                rready[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060096_regfile_mp
// Self-checking bench: a behavioural register-file model produces expected
// read data, ready flags and busy count, which are queued when stimulus is
// applied and popped when the DUT outputs are sampled.
// ---------------------------------------------------------------------------
module tb_ysyx_23060096_regfile_mp;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR    = 4;
    localparam int NW    = 2;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NR*AW-1:0]     raddr;
    logic [NR*DW-1:0]     rdata;
    logic [NR-1:0]        rready;
    logic [NW-1:0]        wen;
    logic [NW*AW-1:0]     waddr;
    logic [NW*DW-1:0]     wdata;
    logic [NW-1:0]        rsv_en;
    logic [NW*AW-1:0]     rsv_addr;
    logic                 flush;
    logic [AW:0]          busy_cnt;

    ysyx_23060096_regfile_mp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NR_RD      (NR),
        .NR_WR      (NW),
        .ZERO_REG   (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raddr    (raddr),
        .rdata    (rdata),
        .rready   (rready),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    // ---------------- scoreboard / model ----------------
    logic [DW-1:0]    exp_q[$];
    logic [DW-1:0]    m_rf [DEPTH];
    logic [DEPTH-1:0] m_busy;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_popcount();
        logic [DW-1:0] c = '0;
        for (int r = 0; r < DEPTH; r++) c = c + DW'(m_busy[r]);
        return c;
    endfunction

    task automatic push_expected();
        logic [NR-1:0] rdy;
        for (int i = 0; i < NR; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = raddr[i*AW +: AW];
            d = m_rf[a];
            rdy[i] = !m_busy[a];
`ifdef YSYX_RF_BYPASS_EN
            for (int j = 0; j < NW; j++) begin
                if (wen[j] && waddr[j*AW +: AW] == a) begin
                    d = wdata[j*DW +: DW];
                    rdy[i] = 1'b1;
                end
            end
`endif
            if (a == 0) begin
                d = '0;
                rdy[i] = 1'b1;
            end
            exp_q.push_back(d);
        end
        exp_q.push_back(DW'(rdy));
        exp_q.push_back(m_popcount());
    endtask

    task automatic compare_outputs();
        if (exp_q.size() < NR + 2) begin
            check("exp_q_underflow", DW'(exp_q.size()), DW'(NR + 2));
        end else begin
            for (int i = 0; i < NR; i++) begin
                check($sformatf("rdata%0d", i), rdata[i*DW +: DW], exp_q.pop_front());
            end
            check("rready", DW'(rready), exp_q.pop_front());
            check("busy_cnt", DW'(busy_cnt), exp_q.pop_front());
        end
    endtask

    // Applies the clock-edge effect of the current inputs to the model.
    task automatic model_update();
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) m_rf[r] = '0;
            m_busy = '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wen[j] && waddr[j*AW +: AW] != 0) m_rf[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
            end
            if (flush) begin
                m_busy = '0;
            end else begin
                for (int j = 0; j < NW; j++) if (wen[j]) m_busy[waddr[j*AW +: AW]] = 1'b0;
                for (int j = 0; j < NW; j++) if (rsv_en[j]) m_busy[rsv_addr[j*AW +: AW]] = 1'b1;
            end
            m_busy[0] = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        rst = 1'b0; wen = '0; rsv_en = '0; flush = 1'b0;
    endtask

    task automatic wr(input int j, input int a, input logic [DW-1:0] d);
        wen[j] = 1'b1;
        waddr[j*AW +: AW] = AW'(a);
        wdata[j*DW +: DW] = d;
    endtask

    task automatic rsv(input int j, input int a);
        rsv_en[j] = 1'b1;
        rsv_addr[j*AW +: AW] = AW'(a);
    endtask

    task automatic rd(input int i, input int a);
        raddr[i*AW +: AW] = AW'(a);
    endtask

    // Inputs are stable here; outputs sampled 1 time unit later, mid-cycle.
    task automatic sample();
        push_expected();
        #1;
        compare_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        raddr = '0; waddr = '0; wdata = '0; rsv_addr = '0;
        rst = 1'b1;
        @(negedge clk);
        advance();
        rst = 1'b0;

        // Post-reset reads
        rd(0, 1); rd(1, 2); rd(2, 3); rd(3, 31);
        sample();
        check("reset_rdata3", rdata[3*DW +: DW], 32'h0);
        check("reset_rready", DW'(rready), 32'hf);
        check("reset_cnt", DW'(busy_cnt), 32'h0);
        advance();

        // Two ports hit r5 in one cycle: port 1 wins
        idle(); wr(0, 5, 32'hDEADBEEF); wr(1, 5, 32'h12345678);
        sample(); advance();
        idle(); rd(0, 5);
        sample();
        check("r5_port1_wins", rdata[DW-1:0], 32'h12345678);
        advance();

        // r0 write and reserve are both ignored
        idle(); wr(0, 0, 32'hFFFFFFFF); rsv(0, 0); rd(0, 0);
        sample(); advance();
        idle(); rd(0, 0);
        sample();
        check("r0_data", rdata[DW-1:0], 32'h0);
        check("r0_ready", DW'(rready[0]), 32'h1);
        check("r0_cnt", DW'(busy_cnt), 32'h0);
        advance();

        // Reserve r7 then write it back
        idle(); rsv(0, 7);
        sample(); advance();
        idle(); rd(1, 7);
        sample();
        check("r7_busy", DW'(rready[1]), 32'h0);
        check("r7_cnt1", DW'(busy_cnt), 32'h1);
        advance();
        idle(); wr(0, 7, 32'hA5);
        sample(); advance();
        idle(); rd(1, 7);
        sample();
        check("r7_ready", DW'(rready[1]), 32'h1);
        check("r7_data", rdata[DW +: DW], 32'hA5);
        check("r7_cnt0", DW'(busy_cnt), 32'h0);
        advance();

        // Reserve beats same-cycle writeback; flush beats reserve
        idle(); wr(1, 9, 32'h99); rsv(0, 9);
        sample(); advance();
        idle(); rd(2, 9);
        sample();
        check("r9_busy", DW'(rready[2]), 32'h0);
        check("r9_cnt", DW'(busy_cnt), 32'h1);
        advance();
        idle(); flush = 1'b1; rsv(1, 10);
        sample(); advance();
        idle(); rd(2, 9); rd(3, 10);
        sample();
        check("flush_ready", DW'(rready[3:2]), 32'h3);
        check("flush_cnt", DW'(busy_cnt), 32'h0);
        advance();

        // Same-cycle read of a register being written back
        idle(); rsv(0, 3);
        sample(); advance();
        idle(); wr(0, 3, 32'h55); rd(0, 3);
        sample();
`ifdef YSYX_RF_BYPASS_EN
        check("byp_data", rdata[DW-1:0], 32'h55);
        check("byp_ready", DW'(rready[0]), 32'h1);
`else
        check("nobyp_data", rdata[DW-1:0], 32'h0);
        check("nobyp_ready", DW'(rready[0]), 32'h0);
`endif
        advance();

        // Random traffic, addresses biased to a small set to force collisions
        for (int n = 0; n < 400; n++) begin
            idle();
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 15) == 0);
            for (int j = 0; j < NW; j++) begin
                if ($urandom_range(0, 1) == 1)
                    wr(j, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31), $urandom());
                if ($urandom_range(0, 2) == 0)
                    rsv(j, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            end
            for (int i = 0; i < NR; i++) begin
                rd(i, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            end
            sample();
            advance();
        end

        idle();
        if (exp_q.size() != 0) check("exp_q_leftover", DW'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
